// File: rtl/song_sequencer_if.sv
// Control / ROM / tone-generator signal bundle for the song sequencer.
// The master side is the sequencer; the slave side is everything around it
// (user controls, the pitch ROM and the tone generator).
interface song_sequencer_if #(
  parameter int INDEX_W = 11
) ();
  logic               play;
  logic               stop;
  logic               loop;
  logic [6:0]         pitch_in;
  logic [INDEX_W-1:0] note_index;
  logic [6:0]         note_pitch;
  logic               note_on;
  logic               note_start;
  logic               busy;
  logic               done;

  modport master (
    input  play, stop, loop, pitch_in,
    output note_index, note_pitch, note_on, note_start, busy, done
  );

  modport slave (
    output play, stop, loop, pitch_in,
    input  note_index, note_pitch, note_on, note_start, busy, done
  );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks a pitch ROM at a fixed tempo and drives a tone
// generator with a latched pitch, a gate (with articulation gap) and a
// note-start strobe. Supports play/pause, stop and looping.
module song_sequencer #(
  parameter int TICK_DIV   = 781250,
  parameter int NOTE_TICKS = 8,
  parameter int GAP_TICKS  = 1,
  parameter int SONG_LEN   = 29,
  parameter int INDEX_W    = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  song_sequencer_if.master   bus
);

  localparam int SOUND_TICKS = NOTE_TICKS - GAP_TICKS;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TCNT_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam bit HAS_GAP = (GAP_TICKS > 0);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0]   DIV_ZERO   = {DIV_W{1'b0}};
  localparam logic [TCNT_W-1:0]  SOUND_LAST = TCNT_W'(SOUND_TICKS - 1);
  localparam logic [TCNT_W-1:0]  GAP_LAST   = TCNT_W'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
  localparam logic [TCNT_W-1:0]  TCNT_ONE   = TCNT_W'(1);
  localparam logic [TCNT_W-1:0]  TCNT_ZERO  = {TCNT_W{1'b0}};
  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(SONG_LEN - 1);
  localparam logic [INDEX_W-1:0] IDX_ONE    = INDEX_W'(1);
  localparam logic [INDEX_W-1:0] IDX_ZERO   = {INDEX_W{1'b0}};

  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_load   = 3'd1,
    st_sound  = 3'd2,
    st_gap    = 3'd3,
    st_paused = 3'd4
  } state_t;

  state_t              state_r,  state_nxt_s;
  state_t              resume_r, resume_nxt_s;
  logic [DIV_W-1:0]    div_r,    div_nxt_s;
  logic [TCNT_W-1:0]   tcnt_r,   tcnt_nxt_s;
  logic [INDEX_W-1:0]  idx_r,    idx_nxt_s;
  logic [6:0]          pitch_r,  pitch_nxt_s;
  logic                on_r,     on_nxt_s;
  logic                start_r,  start_nxt_s;
  logic                busy_r,   busy_nxt_s;
  logic                done_r,   done_nxt_s;

  logic                tick_s;
  logic [TCNT_W-1:0]   phase_last_s;
  logic                phase_end_s;
  logic                last_note_s;

  // Tempo tick and phase-expiry decode from the divider and tick counter
  always_comb begin
    tick_s       = (div_r == DIV_LAST);
    phase_last_s = (state_r == st_gap) ? GAP_LAST : SOUND_LAST;
    phase_end_s  = tick_s && (tcnt_r == phase_last_s);
    last_note_s  = (idx_r >= LAST_INDEX);
  end

  // Next-state and next-output logic; stop overrides everything but reset
  always_comb begin
    state_nxt_s  = state_r;
    resume_nxt_s = resume_r;
    div_nxt_s    = div_r;
    tcnt_nxt_s   = tcnt_r;
    idx_nxt_s    = idx_r;
    pitch_nxt_s  = pitch_r;
    on_nxt_s     = on_r;
    start_nxt_s  = 1'b0;
    done_nxt_s   = 1'b0;

    if (bus.stop && (state_r != st_idle)) begin
      state_nxt_s  = st_idle;
      resume_nxt_s = st_sound;
      div_nxt_s    = DIV_ZERO;
      tcnt_nxt_s   = TCNT_ZERO;
      idx_nxt_s    = IDX_ZERO;
      pitch_nxt_s  = 7'd0;
      on_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        st_idle: begin
          idx_nxt_s = IDX_ZERO;
          on_nxt_s  = 1'b0;
          if (bus.play && !bus.stop) begin
            state_nxt_s = st_load;
          end else begin
            state_nxt_s = st_idle;
          end
        end

        // The ROM address has been stable for at least a cycle here, so
        // pitch_in can be latched directly. Pause is deferred to SOUND.
        st_load: begin
          pitch_nxt_s = bus.pitch_in;
          on_nxt_s    = (bus.pitch_in != 7'd0);
          start_nxt_s = 1'b1;
          div_nxt_s   = DIV_ZERO;
          tcnt_nxt_s  = TCNT_ZERO;
          state_nxt_s = st_sound;
        end

        // A cycle that sees play=0 is not counted, so the remaining
        // duration after resume is exact.
        st_sound, st_gap: begin
          if (!bus.play) begin
            state_nxt_s  = st_paused;
            resume_nxt_s = state_r;
            on_nxt_s     = 1'b0;
          end else if (phase_end_s) begin
            div_nxt_s  = DIV_ZERO;
            tcnt_nxt_s = TCNT_ZERO;
            if ((state_r == st_sound) && HAS_GAP) begin
              state_nxt_s = st_gap;
              on_nxt_s    = 1'b0;
            end else if (!last_note_s) begin
              idx_nxt_s   = idx_r + IDX_ONE;
              state_nxt_s = st_load;
            end else if (bus.loop) begin
              idx_nxt_s   = IDX_ZERO;
              state_nxt_s = st_load;
            end else begin
              idx_nxt_s   = IDX_ZERO;
              pitch_nxt_s = 7'd0;
              on_nxt_s    = 1'b0;
              done_nxt_s  = 1'b1;
              state_nxt_s = st_idle;
            end
          end else if (tick_s) begin
            div_nxt_s  = DIV_ZERO;
            tcnt_nxt_s = tcnt_r + TCNT_ONE;
          end else begin
            div_nxt_s = div_r + DIV_ONE;
          end
        end

        // Counters stay frozen; the gate only comes back when resuming SOUND
        st_paused: begin
          on_nxt_s = 1'b0;
          if (bus.play) begin
            state_nxt_s = resume_r;
            on_nxt_s    = (resume_r == st_sound) ? (pitch_r != 7'd0) : 1'b0;
          end else begin
            state_nxt_s = st_paused;
          end
        end

        default: begin
          state_nxt_s  = st_idle;
          resume_nxt_s = st_sound;
          div_nxt_s    = DIV_ZERO;
          tcnt_nxt_s   = TCNT_ZERO;
          idx_nxt_s    = IDX_ZERO;
          pitch_nxt_s  = 7'd0;
          on_nxt_s     = 1'b0;
        end
      endcase
    end

    busy_nxt_s = (state_nxt_s != st_idle);
  end

  // State, counters and all outputs are registered here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= st_idle;
      resume_r <= st_sound;
      div_r    <= DIV_ZERO;
      tcnt_r   <= TCNT_ZERO;
      idx_r    <= IDX_ZERO;
      pitch_r  <= 7'd0;
      on_r     <= 1'b0;
      start_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      resume_r <= resume_nxt_s;
      div_r    <= div_nxt_s;
      tcnt_r   <= tcnt_nxt_s;
      idx_r    <= idx_nxt_s;
      pitch_r  <= pitch_nxt_s;
      on_r     <= on_nxt_s;
      start_r  <= start_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign bus.note_index = idx_r;
  assign bus.note_pitch = pitch_r;
  assign bus.note_on    = on_r;
  assign bus.note_start = start_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule
